// File: rtl/bus_arbiter_2m_pkg.sv
// Shared definitions for the two-master bus arbiter: state encodings,
// default bus widths and the hold-counter type.
package bus_arbiter_2m_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 64;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_G0   = 2'b01;
  localparam logic [1:0] ST_G1   = 2'b10;

  // HOLD_MAX tops out at 255, so 8 bits always hold HOLD_MAX-1.
  typedef logic [7:0] hold_cnt_t;

  // Grant state for a master index (0 -> G0, 1 -> G1).
  function automatic logic [1:0] grant_state(input logic idx);
    return idx ? ST_G1 : ST_G0;
  endfunction

endpackage

// File: rtl/bus_mux2_master.sv
// Selects the granted master's {wr, addr, dout} onto the shared bus, zeros when idle.
// Latency: combinational.
// Backpressure: none; grants are assumed one-hot or zero.
module bus_mux2_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic              grant0,
  input  logic              grant1,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_dout,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_dout,
  output logic              y_wr,
  output logic [ADDR_W-1:0] y_addr,
  output logic [DATA_W-1:0] y_dout
);

  always_comb begin
    y_wr   = 1'b0;
    y_addr = '0;
    y_dout = '0;
    if (grant0) begin
      y_wr   = a_wr;
      y_addr = a_addr;
      y_dout = a_dout;
    end else if (grant1) begin
      y_wr   = b_wr;
      y_addr = b_addr;
      y_dout = b_dout;
    end
  end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Round-robin arbiter for two masters sharing one bus port, with a per-tenure hold limit.
// Latency: grant registered one cycle after request; data path is combinational from the grant.
// Backpressure: a master waits with req high until granted; owner keeps the bus up to HOLD_MAX cycles when contested.
module bus_arbiter_2m
  import bus_arbiter_2m_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_dout
);

  localparam hold_cnt_t HOLD_LAST = hold_cnt_t'(HOLD_MAX - 1);

  logic [1:0] state, state_nxt;
  logic       last, last_nxt;
  hold_cnt_t  hold_cnt, hold_cnt_nxt;

  logic owner;
  logic own_req;
  logic oth_req;
  logic tenure_end;

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    hold_cnt_nxt = hold_cnt;
    owner        = (state == ST_G1);
    own_req      = owner ? m1_req : m0_req;
    oth_req      = owner ? m0_req : m1_req;
    tenure_end   = !own_req || (hold_cnt == HOLD_LAST);

    case (state)
      ST_IDLE: begin
        hold_cnt_nxt = '0;
        // On a tie, the master that did not own the bus last wins.
        if (m0_req && m1_req) begin
          state_nxt = grant_state(!last);
        end else if (m0_req) begin
          state_nxt = ST_G0;
        end else if (m1_req) begin
          state_nxt = ST_G1;
        end
      end
      ST_G0, ST_G1: begin
        if (tenure_end) begin
          hold_cnt_nxt = '0;
          if (oth_req) begin
            state_nxt = grant_state(!owner);
            last_nxt  = owner;
          end else if (!own_req) begin
            state_nxt = ST_IDLE;
            last_nxt  = owner;
          end
          // Expired with no contender: keep the bus and restart the tenure.
        end else begin
          hold_cnt_nxt = hold_cnt + hold_cnt_t'(1);
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  assign m0_grant = (state == ST_G0);
  assign m1_grant = (state == ST_G1);
  assign bus_req  = m0_grant | m1_grant;

  bus_mux2_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .grant0 (m0_grant),
    .grant1 (m1_grant),
    .a_wr   (m0_wr),
    .a_addr (m0_addr),
    .a_dout (m0_dout),
    .b_wr   (m1_wr),
    .b_addr (m1_addr),
    .b_dout (m1_dout),
    .y_wr   (bus_wr),
    .y_addr (bus_addr),
    .y_dout (bus_dout)
  );

endmodule
